// File: rtl/pipe_skid_stage.sv
// Purpose  : elastic pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Latency  : 1 cycle from in_fire to out_valid_o when empty; sustains one beat per cycle.
// Backpres.: in_ready_o comes from registered state only (low when both entries held).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         drop all held entries (same-cycle input beat discarded)
//   clr_stats_i     clear the stall counter
//   in_valid_i/in_ready_o/in_data_i     upstream handshake + payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake + payload (main entry)
//   occupancy_o     number of held entries (0..2)
//   stall_cnt_o     saturating count of cycles with out_valid_o & !out_ready_i
module pipe_skid_stage #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              clr_stats_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire;
  logic              out_fire;

  assign in_ready_o  = (state != ST_TWO);
  assign out_valid_o = (state != ST_EMPTY);
  assign occupancy_o = state;
  assign out_data_o  = main_q;
  assign stall_cnt_o = stall_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      // A same-cycle out_fire was already sampled downstream; nothing to undo.
      // Payload registers are left as-is, only the state is emptied.
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state  <= ST_ONE;
            main_q <= in_data_i;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data_i;
          end else if (in_fire) begin
            state  <= ST_TWO;
            skid_q <= in_data_i;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so only the drain path exists.
          if (out_fire) begin
            state  <= ST_ONE;
            main_q <= skid_q;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Stall counter: clear wins over increment; flush has no effect on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (clr_stats_i) begin
      stall_q <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Purpose  : directed and scoreboard-driven bench for pipe_skid_stage.
// Latency  : n/a (testbench).
// Backpres.: n/a (testbench).
module tb_pipe_skid_stage;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          clr_stats_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [1:0]    occupancy_o;
  logic [CW-1:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .clr_stats_i (clr_stats_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave us 1 time unit past the edge for driving and sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the random phase.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data;
  logic [CW-1:0] exp_cnt;
  logic          m_in_rdy, m_out_vld, in_f, out_f;

  initial begin
    rst = 1'b1; flush_i = 1'b0; clr_stats_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    step(); step();

    // Reset state
    check_eq("rst_out_valid", out_valid_o, 0);
    check_eq("rst_out_data",  out_data_o,  0);
    check_eq("rst_occ",       occupancy_o, 0);
    check_eq("rst_in_ready",  in_ready_o,  1);
    check_eq("rst_stall",     stall_cnt_o, 0);
    rst = 1'b0;

    // 1: streaming pass-through
    out_ready_i = 1'b1; in_valid_i = 1'b1;
    in_data_i = 16'hA1; step();
    check_eq("t1_d1", out_data_o, 16'hA1);
    check_eq("t1_occ", occupancy_o, 1);
    in_data_i = 16'hA2; step();
    check_eq("t1_d2", out_data_o, 16'hA2);
    in_data_i = 16'hA3; step();
    check_eq("t1_d3", out_data_o, 16'hA3);
    check_eq("t1_occ3", occupancy_o, 1);
    in_valid_i = 1'b0; step();
    check_eq("t1_drain_occ", occupancy_o, 0);
    check_eq("t1_stall", stall_cnt_o, 0);
    check_eq("t1_hold_data", out_data_o, 16'hA3);

    // 2: fill to TWO under backpressure, then drain in order
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    in_data_i = 16'hB1; step();
    in_data_i = 16'hB2; step();
    in_data_i = 16'hB3;
    check_eq("t2_occ2", occupancy_o, 2);
    check_eq("t2_in_ready", in_ready_o, 0);
    check_eq("t2_stall1", stall_cnt_o, 1);
    step();
    check_eq("t2_hold_occ", occupancy_o, 2);
    check_eq("t2_hold_main", out_data_o, 16'hB1);
    check_eq("t2_stall2", stall_cnt_o, 2);
    out_ready_i = 1'b1; step();
    check_eq("t2_o2", out_data_o, 16'hB2);
    check_eq("t2_occ_after", occupancy_o, 1);
    step();
    check_eq("t2_o3", out_data_o, 16'hB3);
    in_valid_i = 1'b0; step();
    check_eq("t2_empty", out_valid_o, 0);
    check_eq("t2_stall_final", stall_cnt_o, 2);

    // 3: flush in TWO with simultaneous out_fire and in_valid
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    in_data_i = 16'hC1; step();
    in_data_i = 16'hC2; step();
    check_eq("t3_occ2", occupancy_o, 2);
    flush_i = 1'b1; out_ready_i = 1'b1; in_data_i = 16'hC9;
    check_eq("t3_deliver_vld", out_valid_o, 1);
    check_eq("t3_deliver_dat", out_data_o, 16'hC1);
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_eq("t3_post_vld", out_valid_o, 0);
    check_eq("t3_post_occ", occupancy_o, 0);
    step(); step();
    check_eq("t3_no_ghost", out_valid_o, 0);
    check_eq("t3_stall", stall_cnt_o, 3);
    in_valid_i = 1'b1; in_data_i = 16'hD1; step();
    check_eq("t3_next_beat", out_data_o, 16'hD1);
    in_valid_i = 1'b0; step();

    // 4: counter saturation and clear
    clr_stats_i = 1'b1; step();
    clr_stats_i = 1'b0;
    check_eq("t4_clr0", stall_cnt_o, 0);
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 16'hE1; step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("t4_at15", stall_cnt_o, 15);
    for (int i = 0; i < 5; i++) step();
    check_eq("t4_sat", stall_cnt_o, 15);
    clr_stats_i = 1'b1; step();
    clr_stats_i = 1'b0;
    check_eq("t4_clr", stall_cnt_o, 0);
    step();
    check_eq("t4_restart", stall_cnt_o, 1);

    // 5: reset mid-stream in TWO
    in_valid_i = 1'b1; in_data_i = 16'hE2; step();
    check_eq("t5_occ2", occupancy_o, 2);
    rst = 1'b1; out_ready_i = 1'b1; in_data_i = 16'hF0; step();
    check_eq("t5_vld", out_valid_o, 0);
    check_eq("t5_dat", out_data_o, 0);
    check_eq("t5_occ", occupancy_o, 0);
    check_eq("t5_rdy", in_ready_o, 1);
    check_eq("t5_stall", stall_cnt_o, 0);
    rst = 1'b0;
    in_data_i = 16'hF1; step();
    check_eq("t5_f1", out_data_o, 16'hF1);
    in_data_i = 16'hF2; step();
    check_eq("t5_f2", out_data_o, 16'hF2);
    in_valid_i = 1'b0; step();
    check_eq("t5_empty", occupancy_o, 0);

    // 6: random traffic against a queue model
    clr_stats_i = 1'b1; step();
    clr_stats_i = 1'b0;
    exp_data = 16'hF2;
    exp_cnt  = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid_i  = ($urandom % 4) != 0;
      out_ready_i = ($urandom % 3) != 0;
      in_data_i   = DW'($urandom);
      flush_i     = ($urandom % 64) == 0;
      clr_stats_i = ($urandom % 128) == 0;

      m_in_rdy  = q.size() < 2;
      m_out_vld = q.size() > 0;
      check_eq("r_in_ready",  in_ready_o,  m_in_rdy);
      check_eq("r_out_valid", out_valid_o, m_out_vld);
      check_eq("r_out_data",  out_data_o,  exp_data);
      check_eq("r_occ",       occupancy_o, q.size());
      check_eq("r_stall",     stall_cnt_o, exp_cnt);

      in_f  = in_valid_i && m_in_rdy;
      out_f = m_out_vld && out_ready_i;
      if (clr_stats_i) exp_cnt = '0;
      else if (m_out_vld && !out_ready_i && exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;

      step();

      if (flush_i) begin
        q.delete();
      end else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(in_data_i);
        if (q.size() > 0) exp_data = q[0];
      end
    end
    in_valid_i = 1'b0; flush_i = 1'b0; clr_stats_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
